// File: rtl/reg_port_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// reg_port_arbiter: round-robin sharing of one reg_file write/read port pair
// between requesters A and B using a fixed IDLE -> ISSUE -> DONE transaction.
// Revision: 1.0
// ---------------------------------------------------------------------------
module reg_port_arbiter #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_gnt,
  output logic                  a_done,
  output logic [DATA_WIDTH-1:0] a_rdata,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_gnt,
  output logic                  b_done,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic                  rf_wen,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic [ADDR_WIDTH-1:0] rf_raddr,
  input  logic [DATA_WIDTH-1:0] rf_rdata,
  output logic                  busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e                  state_q,     state_d;
  logic                    last_b_q,    last_b_d;
  logic                    cmd_b_q,     cmd_b_d;
  logic                    cmd_we_q,    cmd_we_d;
  logic [ADDR_WIDTH-1:0]   cmd_addr_q,  cmd_addr_d;
  logic [DATA_WIDTH-1:0]   cmd_wdata_q, cmd_wdata_d;
  logic [DATA_WIDTH-1:0]   a_rdata_q,   a_rdata_d;
  logic [DATA_WIDTH-1:0]   b_rdata_q,   b_rdata_d;
  logic                    win_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      last_b_q    <= 1'b1;
      cmd_b_q     <= 1'b0;
      cmd_we_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      a_rdata_q   <= '0;
      b_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      last_b_q    <= last_b_d;
      cmd_b_q     <= cmd_b_d;
      cmd_we_q    <= cmd_we_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      a_rdata_q   <= a_rdata_d;
      b_rdata_q   <= b_rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    last_b_d    = last_b_q;
    cmd_b_d     = cmd_b_q;
    cmd_we_d    = cmd_we_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    a_rdata_d   = a_rdata_q;
    b_rdata_d   = b_rdata_q;
    // B wins when alone, or when both ask and A was the previous winner.
    win_b       = b_req && (!a_req || !last_b_q);
    case (state_q)
      S_IDLE: begin
        if (a_req || b_req) begin
          cmd_b_d     = win_b;
          cmd_we_d    = win_b ? b_we    : a_we;
          cmd_addr_d  = win_b ? b_addr  : a_addr;
          cmd_wdata_d = win_b ? b_wdata : a_wdata;
          last_b_d    = win_b;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!cmd_we_q) begin
          if (cmd_b_q) b_rdata_d = rf_rdata;
          else         a_rdata_d = rf_rdata;
        end
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign rf_waddr = cmd_addr_q;
  assign rf_raddr = cmd_addr_q;
  assign rf_wdata = cmd_wdata_q;
  assign rf_wen   = (state_q == S_ISSUE) && cmd_we_q;
  assign a_gnt    = (state_q == S_ISSUE) && !cmd_b_q;
  assign b_gnt    = (state_q == S_ISSUE) &&  cmd_b_q;
  assign a_done   = (state_q == S_DONE)  && !cmd_b_q;
  assign b_done   = (state_q == S_DONE)  &&  cmd_b_q;
  assign a_rdata  = a_rdata_q;
  assign b_rdata  = b_rdata_q;
  assign busy     = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_reg_port_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_reg_port_arbiter: directed table, reset corner case and randomized
// transactions against a transaction-level model of the arbiter.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_reg_port_arbiter;

  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          a_req, a_we, b_req, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;
  logic          a_gnt, a_done, b_gnt, b_done;
  logic [DW-1:0] a_rdata, b_rdata;
  logic [AW-1:0] rf_waddr, rf_raddr;
  logic          rf_wen;
  logic [DW-1:0] rf_wdata, rf_rdata;
  logic          busy;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  reg_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_done(a_done), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_done(b_done), .b_rdata(b_rdata),
    .rf_waddr(rf_waddr), .rf_wen(rf_wen), .rf_wdata(rf_wdata),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .busy(busy)
  );

  // Environment register file: combinational read, write on the clock edge.
  logic [DW-1:0] rf_mem [32] = '{default: '0};
  always @(posedge clk) if (rf_wen) rf_mem[rf_waddr] <= rf_wdata;
  assign rf_rdata = rf_mem[rf_raddr];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Protocol monitors: no overlapping grants, no back-to-back wen, done follows gnt.
  logic prev_wen = 1'b0, prev_ag = 1'b0, prev_bg = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      if (a_gnt && b_gnt)        chk("gnt_overlap", 1, 0);
      if (rf_wen && prev_wen)    chk("wen_consecutive", 1, 0);
      if (a_done)                chk("a_done_after_gnt", prev_ag, 1);
      if (b_done)                chk("b_done_after_gnt", prev_bg, 1);
      prev_wen = rf_wen; prev_ag = a_gnt; prev_bg = b_gnt;
    end else begin
      prev_wen = 1'b0; prev_ag = 1'b0; prev_bg = 1'b0;
    end
  end

  // Transaction-level model state.
  logic [DW-1:0] shadow [32];
  logic [DW-1:0] exp_a_rd, exp_b_rd;
  bit            last_a;

  // Called at posedge+1 of an IDLE cycle with requests already driven.
  task automatic txn(input int win, input bit we, input logic [AW-1:0] addr,
                     input logic [DW-1:0] wd, input logic [DW-1:0] rd);
    @(posedge clk); #1;
    chk("a_gnt", a_gnt, win == 1);
    chk("b_gnt", b_gnt, win == 2);
    chk("busy_issue", busy, 1);
    chk("rf_wen_issue", rf_wen, we);
    chk("rf_waddr", rf_waddr, addr);
    chk("rf_raddr", rf_raddr, addr);
    if (we) chk("rf_wdata", rf_wdata, wd);
    if (win == 1) a_req = 1'b0; else b_req = 1'b0;
    @(posedge clk); #1;
    if (!we) begin
      if (win == 1) exp_a_rd = rd; else exp_b_rd = rd;
    end
    chk("a_done", a_done, win == 1);
    chk("b_done", b_done, win == 2);
    chk("rf_wen_done", rf_wen, 0);
    chk("a_rdata", a_rdata, exp_a_rd);
    chk("b_rdata", b_rdata, exp_b_rd);
    @(posedge clk); #1;
    chk("busy_idle", busy, 0);
    chk("done_cleared", {a_done, b_done}, 0);
    if (we) shadow[addr] = wd;
    last_a = (win == 1);
  endtask

  typedef struct {
    bit            a_req; bit a_we; logic [AW-1:0] a_addr; logic [DW-1:0] a_wd;
    bit            b_req; bit b_we; logic [AW-1:0] b_addr; logic [DW-1:0] b_wd;
    int            win;   logic [DW-1:0] rd;
  } vec_t;

  vec_t vecs[9];

  initial begin
    vecs[0] = '{1, 1, 5'd3, 32'hA5A5_0001, 0, 0, 5'd0, 32'h0,  1, 32'h0};
    vecs[1] = '{0, 0, 5'd0, 32'h0,         1, 0, 5'd3, 32'h0,  2, 32'hA5A5_0001};
    vecs[2] = '{1, 1, 5'd1, 32'h11,        1, 1, 5'd2, 32'h22, 1, 32'h0};
    vecs[3] = '{0, 0, 5'd0, 32'h0,         1, 1, 5'd2, 32'h22, 2, 32'h0};
    vecs[4] = '{1, 0, 5'd1, 32'h0,         1, 0, 5'd2, 32'h0,  1, 32'h11};
    vecs[5] = '{1, 0, 5'd3, 32'h0,         1, 0, 5'd2, 32'h0,  2, 32'h22};
    vecs[6] = '{1, 0, 5'd3, 32'h0,         1, 0, 5'd1, 32'h0,  1, 32'hA5A5_0001};
    vecs[7] = '{0, 0, 5'd0, 32'h0,         1, 0, 5'd1, 32'h0,  2, 32'h11};
    vecs[8] = '{0, 0, 5'd0, 32'h0,         1, 0, 5'd7, 32'h0,  2, 32'h0};

    for (int i = 0; i < 32; i++) shadow[i] = '0;
    exp_a_rd = '0; exp_b_rd = '0; last_a = 1'b0;
    a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_gnt", {a_gnt, b_gnt}, 0);
    chk("rst_done", {a_done, b_done}, 0);
    chk("rst_wen", rf_wen, 0);
    chk("rst_addr", {rf_waddr, rf_raddr}, 0);
    chk("rst_wdata", rf_wdata, 0);
    chk("rst_rdata", {a_rdata, b_rdata}, 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // Directed table: each entry is one transaction starting from IDLE.
    for (int i = 0; i < 9; i++) begin
      a_req = vecs[i].a_req; a_we = vecs[i].a_we; a_addr = vecs[i].a_addr; a_wdata = vecs[i].a_wd;
      b_req = vecs[i].b_req; b_we = vecs[i].b_we; b_addr = vecs[i].b_addr; b_wdata = vecs[i].b_wd;
      if (vecs[i].win == 1)
        txn(1, vecs[i].a_we, vecs[i].a_addr, vecs[i].a_wd, vecs[i].rd);
      else
        txn(2, vecs[i].b_we, vecs[i].b_addr, vecs[i].b_wd, vecs[i].rd);
    end
    chk("reg3_written", rf_mem[3], 32'hA5A5_0001);

    // Async reset in the ISSUE cycle of a write: nothing must complete.
    a_req = 1; a_we = 1; a_addr = 5'd5; a_wdata = 32'hDEAD_BEEF; b_req = 0;
    @(posedge clk); #1;
    chk("mid_wen_before", rf_wen, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_wen_async", rf_wen, 0);
    chk("mid_busy", busy, 0);
    chk("mid_gnt", a_gnt, 0);
    chk("mid_rdata", {a_rdata, b_rdata}, 0);
    a_req = 0;
    @(posedge clk); #1;
    chk("mid_no_done", {a_done, b_done}, 0);
    @(negedge clk) rst = 1'b0;
    exp_a_rd = '0; exp_b_rd = '0; last_a = 1'b0;
    @(posedge clk); #1;
    chk("reg5_untouched", rf_mem[5], 0);
    a_req = 1; a_we = 0; a_addr = 5'd5;
    b_req = 1; b_we = 0; b_addr = 5'd3;
    txn(1, 0, 5'd5, a_wdata, shadow[5]);
    txn(2, 0, 5'd3, b_wdata, shadow[3]);

    // Randomized transactions checked against the transaction-level model.
    for (int t = 0; t < 300; t++) begin
      int win;
      if (!a_req && ($urandom_range(0, 1) == 1)) begin
        a_req = 1; a_we = $urandom_range(0, 1); a_addr = AW'($urandom_range(0, 7)); a_wdata = $urandom;
      end
      if (!b_req && ($urandom_range(0, 1) == 1)) begin
        b_req = 1; b_we = $urandom_range(0, 1); b_addr = AW'($urandom_range(0, 7)); b_wdata = $urandom;
      end
      if (!a_req && !b_req) begin
        @(posedge clk); #1;
        chk("idle_busy", busy, 0);
        chk("idle_gnt", {a_gnt, b_gnt}, 0);
      end else begin
        if (a_req && b_req) win = last_a ? 2 : 1;
        else                win = a_req ? 1 : 2;
        if (win == 1) txn(1, a_we, a_addr, a_wdata, shadow[a_addr]);
        else          txn(2, b_we, b_addr, b_wdata, shadow[b_addr]);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire
